// File: rtl/instr_cache_refill_ctrl_if.sv
// Miss, replacement-beat and backing-memory signals of the I-cache refill engine.
// master = refill engine, slave = cache set plus memory side.
interface instr_cache_refill_ctrl_if #(
  parameter int AW = 32
);
  logic          MissReq;
  logic [AW-1:0] MissAddr;
  logic          RepEnable;
  logic [63:0]   RepWord;
  logic          RefillBusy;
  logic          MemReq;
  logic [AW-1:0] MemAddr;
  logic          MemValid;
  logic [31:0]   MemRData;

  modport master (
    input  MissReq, MissAddr, MemValid, MemRData,
    output RepEnable, RepWord, RefillBusy, MemReq, MemAddr
  );

  modport slave (
    output MissReq, MissAddr, MemValid, MemRData,
    input  RepEnable, RepWord, RefillBusy, MemReq, MemAddr
  );
endinterface

// File: rtl/instr_cache_refill_ctrl.sv
// I-cache line refill: fetch B/4 words (1 outstanding, MemValid stalls FETCH only), then stream
// B/8 uninterruptible 64-bit beats starting the cycle after the last word, then one DONE cycle.
module instr_cache_refill_ctrl #(
  parameter int B  = 64,
  parameter int AW = 32
) (
  input logic                         clk,
  input logic                         reset,
  instr_cache_refill_ctrl_if.master   bus
);
  localparam int W     = B / 4;
  localparam int BEATS = B / 8;
  localparam int WIDX  = $clog2(W);
  localparam int WCW   = WIDX + 1;
  localparam int BCW   = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [AW-1:0] LMASK = ~(AW'(B) - AW'(1));

  typedef enum logic [1:0] {IDLE, FETCH, STREAM, DONE} state_e;

  state_e         state_q, state_d;
  logic [AW-1:0]  line_q, line_d;
  logic [WCW-1:0] wc_q, wc_d;
  logic [BCW-1:0] bc_q, bc_d;
  logic [31:0]    buf_q [W];

  logic           accept;
  logic           last_word;
  logic           line_match;
  logic [WIDX-1:0] lo_idx;
  logic [WIDX-1:0] hi_idx;

  assign accept     = (state_q == FETCH) && bus.MemValid;
  assign last_word  = (wc_q == WCW'(W - 1));
  assign line_match = bus.MissReq && ((bus.MissAddr & LMASK) == line_q);
  assign lo_idx     = WIDX'({bc_q, 1'b0});
  assign hi_idx     = WIDX'({bc_q, 1'b1});

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      line_q  <= '0;
      wc_q    <= '0;
      bc_q    <= '0;
    end else begin
      state_q <= state_d;
      line_q  <= line_d;
      wc_q    <= wc_d;
      bc_q    <= bc_d;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < W; i++) buf_q[i] <= '0;
    end else if (accept) begin
      buf_q[wc_q[WIDX-1:0]] <= bus.MemRData;
    end
  end

  always_comb begin
    state_d = state_q;
    line_d  = line_q;
    wc_d    = wc_q;
    bc_d    = bc_q;
    case (state_q)
      IDLE: begin
        if (bus.MissReq) begin
          line_d  = bus.MissAddr & LMASK;
          wc_d    = '0;
          state_d = FETCH;
        end
      end
      FETCH: begin
        if (accept) begin
          if (last_word) begin
            wc_d    = '0;
            bc_d    = '0;
            // A miss that moved to another line (or went away) abandons this refill.
            state_d = line_match ? STREAM : IDLE;
          end else begin
            wc_d = wc_q + WCW'(1);
          end
        end
      end
      STREAM: begin
        if (bc_q == BCW'(BEATS - 1)) begin
          bc_d    = '0;
          state_d = DONE;
        end else begin
          bc_d = bc_q + BCW'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs decode registered state only, so no input reaches an output combinationally.
  always_comb begin
    bus.RepEnable  = 1'b0;
    bus.RepWord    = '0;
    bus.RefillBusy = 1'b0;
    bus.MemReq     = 1'b0;
    bus.MemAddr    = '0;
    case (state_q)
      FETCH: begin
        bus.RefillBusy = 1'b1;
        bus.MemReq     = 1'b1;
        bus.MemAddr    = line_q | (AW'(wc_q[WIDX-1:0]) << 2);
      end
      STREAM: begin
        bus.RefillBusy = 1'b1;
        bus.RepEnable  = 1'b1;
        bus.RepWord    = {buf_q[hi_idx], buf_q[lo_idx]};
      end
      DONE:    bus.RefillBusy = 1'b1;
      default: ;
    endcase
  end
endmodule

// File: tb/tb_instr_cache_refill_ctrl.sv
// Randomized bench for the I-cache refill engine with a line-level reference model and scoreboard.
module tb_instr_cache_refill_ctrl;
  localparam int B     = 64;
  localparam int AW    = 32;
  localparam int W     = B / 4;
  localparam int BEATS = B / 8;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  instr_cache_refill_ctrl_if #(.AW(AW)) bus();

  instr_cache_refill_ctrl #(.B(B), .AW(AW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_err = 0;

  logic [AW-1:0] addr_q [$];
  logic [63:0]   beat_q [$];
  logic [31:0]   key   = 32'h0;
  int            wmode = 0;
  int            beats_seen = 0;
  int            acc_seen   = 0;
  int            stream_run = 0;
  int            post       = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, required %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_data(input logic [AW-1:0] a);
    return a ^ key;
  endfunction

  // Reference: a refill reads every word of the line in order; a completed one returns them pairwise.
  task automatic expect_line(input logic [AW-1:0] miss, input bit streams);
    logic [AW-1:0] base;
    base = miss & ~(AW'(B) - AW'(1));
    for (int i = 0; i < W; i++) addr_q.push_back(base + AW'(4 * i));
    if (streams)
      for (int k = 0; k < BEATS; k++)
        beat_q.push_back({mem_data(base + AW'(8 * k + 4)), mem_data(base + AW'(8 * k))});
  endtask

  // Memory model: zero-wait, every third cycle, or random; noise on MemValid while idle.
  initial begin
    int  ph;
    logic v;
    ph = 0;
    bus.MemValid = 1'b0;
    bus.MemRData = '0;
    forever begin
      @(negedge clk);
      if (bus.MemReq) begin
        case (wmode)
          0:       v = 1'b1;
          1:       begin v = (ph % 3 == 2); ph++; end
          default: v = ($urandom_range(0, 2) == 0);
        endcase
        bus.MemValid = v;
        bus.MemRData = v ? mem_data(bus.MemAddr) : $urandom;
      end else begin
        ph = 0;
        bus.MemValid = (wmode == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
        bus.MemRData = $urandom;
      end
    end
  end

  // Monitor: pops expectations whenever the DUT presents a request or a beat.
  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (!reset) begin
        stream_run = 0;
        post       = 0;
      end else begin
        if (bus.MemReq) begin
          if (addr_q.size() == 0) chk("mem_req_unexpected", 64'(bus.MemReq), 64'd0);
          else begin
            chk("mem_addr", 64'(bus.MemAddr), 64'(addr_q[0]));
            if (bus.MemValid) begin
              void'(addr_q.pop_front());
              acc_seen++;
            end
          end
        end
        if (bus.RepEnable) begin
          if (beat_q.size() == 0) chk("rep_unexpected", 64'(bus.RepEnable), 64'd0);
          else chk("rep_word", bus.RepWord, beat_q.pop_front());
          chk("busy_stream", 64'(bus.RefillBusy), 64'd1);
          beats_seen++;
          stream_run++;
        end else if (stream_run != 0) begin
          chk("stream_len", 64'(stream_run), 64'(BEATS));
          chk("done_busy", 64'(bus.RefillBusy), 64'd1);
          chk("done_memreq", 64'(bus.MemReq), 64'd0);
          stream_run = 0;
          post = 1;
        end else if (post == 1) begin
          chk("idle_gap_busy", 64'(bus.RefillBusy), 64'd0);
          post = 0;
        end
      end
    end
  end

  task automatic wait_empty(input string nm);
    int n;
    n = 0;
    while ((addr_q.size() != 0 || beat_q.size() != 0) && n < 400) begin
      @(negedge clk); #2;
      n++;
    end
    if (n >= 400) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s: timeout with %0d addrs / %0d beats pending, required 0",
               nm, addr_q.size(), beat_q.size());
      addr_q.delete();
      beat_q.delete();
    end
  endtask

  task automatic wait_accepts(input string nm, input int target);
    int n;
    n = 0;
    while (acc_seen < target && n < 400) begin
      @(negedge clk); #2;
      n++;
    end
    if (n >= 400) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s: timeout, %0d accepts seen, required %0d", nm, acc_seen, target);
    end
  endtask

  task automatic settle();
    repeat (4) begin @(negedge clk); #2; end
  endtask

  task automatic refill(input logic [AW-1:0] a, input int mode);
    @(negedge clk); #2;
    wmode = mode;
    expect_line(a, 1'b1);
    bus.MissAddr = a;
    bus.MissReq  = 1'b1;
    wait_empty("refill");
    bus.MissReq = 1'b0;
    settle();
  endtask

  task automatic abandon(input logic [AW-1:0] a, input logic [AW-1:0] b, input bit redirect, input int mode);
    int a0;
    @(negedge clk); #2;
    wmode = mode;
    a0 = acc_seen;
    expect_line(a, 1'b0);
    bus.MissAddr = a;
    bus.MissReq  = 1'b1;
    wait_accepts("abandon_mid", a0 + W / 2);
    if (redirect) begin
      bus.MissAddr = b;
      expect_line(b, 1'b1);
    end else begin
      bus.MissReq = 1'b0;
    end
    wait_empty("abandon");
    bus.MissReq = 1'b0;
    settle();
  endtask

  task automatic back_to_back(input logic [AW-1:0] a, input logic [AW-1:0] c, input int mode);
    @(negedge clk); #2;
    wmode = mode;
    expect_line(a, 1'b1);
    bus.MissAddr = a;
    bus.MissReq  = 1'b1;
    wait_empty("b2b_first");
    bus.MissAddr = c;
    expect_line(c, 1'b1);
    repeat (2) begin @(negedge clk); #2; end
    @(negedge clk); #2;
    chk("b2b_restart_memreq", 64'(bus.MemReq), 64'd1);
    wait_empty("b2b_second");
    bus.MissReq = 1'b0;
    settle();
  endtask

  task automatic reset_mid_stream(input logic [AW-1:0] a);
    int b0;
    int n;
    @(negedge clk); #2;
    wmode = 0;
    b0 = beats_seen;
    expect_line(a, 1'b1);
    bus.MissAddr = a;
    bus.MissReq  = 1'b1;
    n = 0;
    while (beats_seen < b0 + 4 && n < 400) begin @(negedge clk); #2; n++; end
    chk("rst_beats_before", 64'(beats_seen - b0), 64'd4);
    reset = 1'b0;
    #1;
    chk("rst_async_rep", 64'(bus.RepEnable), 64'd0);
    chk("rst_async_word", bus.RepWord, 64'd0);
    chk("rst_async_memreq", 64'(bus.MemReq), 64'd0);
    chk("rst_async_busy", 64'(bus.RefillBusy), 64'd0);
    addr_q.delete();
    beat_q.delete();
    repeat (2) begin @(negedge clk); #2; end
    expect_line(a, 1'b1);
    reset = 1'b1;
    wait_empty("rst_restart");
    bus.MissReq = 1'b0;
    settle();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [AW-1:0] ra;
    logic [AW-1:0] rb;
    int kind;
    bus.MissReq  = 1'b0;
    bus.MissAddr = '0;
    repeat (2) @(negedge clk);
    #1;
    chk("reset_rep", 64'(bus.RepEnable), 64'd0);
    chk("reset_word", bus.RepWord, 64'd0);
    chk("reset_memreq", 64'(bus.MemReq), 64'd0);
    chk("reset_memaddr", 64'(bus.MemAddr), 64'd0);
    chk("reset_busy", 64'(bus.RefillBusy), 64'd0);
    #1;
    reset = 1'b1;

    key = 32'h0;
    refill(32'h0000_1234, 0);
    refill(32'h0000_1234, 1);
    abandon(32'h0000_1234, 32'h0000_2000, 1'b1, 0);
    reset_mid_stream(32'h0000_1234);
    back_to_back(32'h0000_1234, 32'h0000_5678, 0);

    for (int it = 0; it < 16; it++) begin
      key  = $urandom;
      ra   = $urandom;
      rb   = $urandom;
      kind = $urandom_range(0, 4);
      case (kind)
        0, 1:    refill(ra, $urandom_range(0, 2));
        2:       abandon(ra, rb ^ 32'h0000_0100, 1'b1, $urandom_range(0, 2));
        3:       abandon(ra, rb, 1'b0, $urandom_range(0, 2));
        default: back_to_back(ra, ra ^ 32'h0001_0000, $urandom_range(0, 2));
      endcase
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
